// File: rtl/fifo_guarded_stats.sv
// Single-clock FWFT FIFO with guarded accesses, runtime almost-full/empty thresholds,
// synchronous flush, sticky error flags, saturating drop counter and occupancy watermark.
module fifo_guarded_stats #(
  parameter int LOG_DEPTH = 10,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wrreq,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  input  logic                 flush,
  input  logic                 err_clr,
  input  logic [LOG_DEPTH:0]   af_thresh,
  input  logic [LOG_DEPTH:0]   ae_thresh,
  output logic [WIDTH-1:0]     q,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [LOG_DEPTH:0]   usedw,
  output logic                 overflow,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [LOG_DEPTH:0]   watermark
);
  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_U = (LOG_DEPTH+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_DEPTH:0]   used, used_nxt, wm_nxt;
  logic                 rd_accept, wr_accept, ovf_evt, udf_evt;

  assign empty        = (used == '0);
  assign full         = (used == DEPTH_U);
  assign usedw        = used;
  assign q            = mem[rd_ptr];
  assign almost_full  = (used >= af_thresh);
  assign almost_empty = (used <= ae_thresh);

  // A write into a full FIFO is legal only when a read frees the head the same edge.
  assign rd_accept = rdreq & ~empty & ~flush;
  assign wr_accept = wrreq & ~flush & (~full | rd_accept);
  assign ovf_evt   = wrreq & ~flush & ~wr_accept;
  assign udf_evt   = rdreq & empty & ~flush;

  always_comb begin
    used_nxt = used;
    if (flush)                        used_nxt = '0;
    else if (wr_accept && !rd_accept) used_nxt = used + 1'b1;
    else if (rd_accept && !wr_accept) used_nxt = used - 1'b1;
    wm_nxt = (used_nxt > watermark) ? used_nxt : watermark;
  end

  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
      watermark <= '0;
    end else begin
      used <= used_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
        if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      end
      // An error event coinciding with err_clr is logged after the clear.
      if (ovf_evt)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_evt)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
      if (ovf_evt) begin
        if (err_clr)          drop_cnt <= CNT_WIDTH'(1);
        else if (~&drop_cnt)  drop_cnt <= drop_cnt + 1'b1;
      end else if (err_clr) begin
        drop_cnt <= '0;
      end
      watermark <= err_clr ? '0 : wm_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_guarded_stats.sv
// Scoreboarded bench for fifo_guarded_stats at DEPTH=4, WIDTH=8, CNT_WIDTH=2.
module tb_fifo_guarded_stats;
  localparam int LD = 2, W = 8, CW = 2, DEPTH = 4;

  logic          clock = 0, reset_n, wrreq, rdreq, flush, err_clr;
  logic [W-1:0]  data, q;
  logic [LD:0]   af_thresh, ae_thresh, usedw, watermark;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] drop_cnt;

  int checks = 0, failures = 0;
  logic [W-1:0] exp_q[$];
  int tb_used = 0;

  fifo_guarded_stats #(.LOG_DEPTH(LD), .WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .flush(flush), .err_clr(err_clr), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .q(q), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .usedw(usedw), .overflow(overflow),
    .underflow(underflow), .drop_cnt(drop_cnt), .watermark(watermark));

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted read presents the head on q; compare against the scoreboard.
  always @(negedge clock) begin
    if (reset_n && rdreq && !flush && !empty) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_data actual=%0h expected=<none>", q);
      end else begin
        chk("rd_data", int'(q), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; the reference occupancy/queue is updated when issued.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r,
                     input logic f = 0, input logic ec = 0);
    bit racc, wacc;
    wrreq = w; data = d; rdreq = r; flush = f; err_clr = ec;
    racc = r && !f && tb_used > 0;
    wacc = w && !f && (tb_used < DEPTH || racc);
    if (f) begin
      exp_q.delete();
      tb_used = 0;
    end else begin
      if (wacc) exp_q.push_back(d);
      tb_used += int'(wacc) - int'(racc);
    end
    @(posedge clock); #1;
    wrreq = 0; rdreq = 0; flush = 0; err_clr = 0;
  endtask

  task automatic chk_flags(input string tag, input int ov, input int ud, input int dc);
    chk({tag, "_overflow"}, int'(overflow), ov);
    chk({tag, "_underflow"}, int'(underflow), ud);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), dc);
  endtask

  int af_tab[5] = '{0, 0, 0, 1, 1};
  int ae_tab[5] = '{1, 1, 0, 0, 0};
  int exp_drop;

  initial begin
    reset_n = 0; wrreq = 0; rdreq = 0; flush = 0; err_clr = 0; data = '0;
    af_thresh = 3'd4; ae_thresh = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_usedw", int'(usedw), 0);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_wm", int'(watermark), 0);
    chk_flags("rst", 0, 0, 0);
    reset_n = 1;

    // 1: back-to-back writes, FWFT head, in-order drain
    cyc(1, 8'hA0, 0);
    chk("t1_q_first", int'(q), 'hA0);
    chk("t1_empty_first", int'(empty), 0);
    for (int i = 1; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0);
    chk("t1_usedw4", int'(usedw), 4);
    chk("t1_full", int'(full), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    chk("t1_empty", int'(empty), 1);
    chk("t1_wm", int'(watermark), 4);

    // 2: overflow drops 5th, read-through write while full keeps order
    for (int i = 0; i < 4; i++) cyc(1, 8'hB0 + 8'(i), 0);
    cyc(1, 8'hB4, 0);
    chk("t2_usedw", int'(usedw), 4);
    chk_flags("t2", 1, 0, 1);
    cyc(1, 8'hC0, 1);
    chk("t2_rt_usedw", int'(usedw), 4);
    chk("t2_rt_drop", int'(drop_cnt), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    chk("t2_empty", int'(empty), 1);
    cyc(0, 0, 0, 0, 1);
    chk_flags("t2_clr", 0, 0, 0);
    chk("t2_clr_wm", int'(watermark), 0);

    // 3: read on empty with concurrent write
    cyc(1, 8'h55, 1);
    chk("t3_underflow", int'(underflow), 1);
    chk("t3_usedw", int'(usedw), 1);
    chk("t3_q", int'(q), 'h55);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk_flags("t3_clr", 0, 0, 0);

    // 4: threshold ramp 0->4->0
    af_thresh = 3'd3; ae_thresh = 3'd1;
    #1;
    chk("t4_af0", int'(almost_full), af_tab[0]);
    chk("t4_ae0", int'(almost_empty), ae_tab[0]);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 8'hD0 + 8'(i), 0);
      chk($sformatf("t4_up_af%0d", i), int'(almost_full), i >= 3 ? 1 : 0);
      chk($sformatf("t4_up_ae%0d", i), int'(almost_empty), i <= 1 ? 1 : 0);
    end
    chk("t4_wm", int'(watermark), 4);
    for (int i = 3; i >= 0; i--) begin
      cyc(0, 0, 1);
      chk($sformatf("t4_dn_af%0d", i), int'(almost_full), af_tab[i]);
      chk($sformatf("t4_dn_ae%0d", i), int'(almost_empty), ae_tab[i]);
    end
    af_thresh = 3'd0; ae_thresh = 3'd4;
    cyc(1, 8'h11, 0);
    cyc(1, 8'h12, 0);
    chk("t4_af_forced", int'(almost_full), 1);
    chk("t4_ae_forced", int'(almost_empty), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    af_thresh = 3'd3; ae_thresh = 3'd1;

    // 5: flush with requests, then err_clr clears watermark
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 8'hE0 + 8'(i), 0);
    cyc(1, 8'hEF, 1, 1);
    chk("t5_usedw", int'(usedw), 0);
    chk("t5_empty", int'(empty), 1);
    chk_flags("t5", 0, 0, 0);
    chk("t5_wm", int'(watermark), 3);
    cyc(0, 0, 0, 0, 1);
    chk("t5_clr_wm", int'(watermark), 0);
    cyc(1, 8'h21, 0);
    chk("t5_q_after_flush", int'(q), 'h21);
    cyc(0, 0, 1);

    // 6: random push/pop across pointer wraps, then drop counter saturation
    cyc(0, 0, 0, 0, 1);
    exp_drop = 0;
    for (int i = 0; i < 60; i++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (w && tb_used == DEPTH && !r && exp_drop < 3) exp_drop++;
      cyc(w, 8'($urandom), r);
      chk("t6_usedw", int'(usedw), tb_used);
    end
    chk("t6_drop", int'(drop_cnt), exp_drop);
    cyc(0, 0, 0, 0, 1);
    while (tb_used < DEPTH) cyc(1, 8'($urandom), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 8'hFF, 0);
      chk($sformatf("t6_sat%0d", i), int'(drop_cnt), i < 3 ? i : 3);
    end

    // Reset mid-traffic drops contents with no errors logged
    cyc(0, 0, 0, 0, 1);
    reset_n = 0; wrreq = 1; rdreq = 1; data = 8'h77;
    exp_q.delete(); tb_used = 0;
    @(posedge clock); #1;
    reset_n = 1; wrreq = 0; rdreq = 0;
    chk("rst2_usedw", int'(usedw), 0);
    chk("rst2_wm", int'(watermark), 0);
    chk_flags("rst2", 0, 0, 0);

    @(posedge clock); #1;
    chk("sb_drained", exp_q.size(), tb_used);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
